// File: rtl/rice_pkg.sv
// Shared definitions for the Rice split-sample block sequencer and its option
// decoder: configuration widths, option-ID code points, legal block sizes,
// FSM state encoding and the option-ID to split-bit (k) mapping.
package rice_pkg;

  localparam int unsigned ID_W      = 4;   // option-ID width (covers n up to 10)
  localparam int unsigned SYM_W     = 10;  // sample width; n_cfg must not exceed it
  localparam int unsigned J_MAX     = 32;  // largest legal block size
  localparam int unsigned CNT_W     = 6;   // width of k, j, n and the sample counter
  localparam int unsigned NCFG_W    = 4;   // width of the n_cfg descriptor field
  localparam int unsigned BLK_CNT_W = 16;  // completed-block counter width

  localparam logic [ID_W-1:0] ID_ZERO   = '0;
  localparam logic [ID_W-1:0] ID_FS     = ID_W'(1);
  localparam logic [ID_W-1:0] ID_NOCOMP = '1;

  localparam logic [CNT_W-1:0] J_8  = CNT_W'(8);
  localparam logic [CNT_W-1:0] J_16 = CNT_W'(16);
  localparam logic [CNT_W-1:0] J_32 = CNT_W'(J_MAX);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    RUN  = 3'd2,
    CAP  = 3'd3,
    DONE = 3'd4
  } state_e;

  // Split bits for an option ID; uncompressed blocks carry all n bits as "split".
  function automatic logic [CNT_W-1:0] opt_to_k(input logic [ID_W-1:0]   id,
                                                input logic [NCFG_W-1:0] n);
    logic [CNT_W-1:0] k;
    if ((id == ID_ZERO) || (id == ID_FS)) k = '0;
    else if (id == ID_NOCOMP)             k = CNT_W'(n);
    else                                  k = CNT_W'(id) - CNT_W'(1);
    return k;
  endfunction

  function automatic logic j_is_legal(input logic [CNT_W-1:0] j);
    return (j == J_8) || (j == J_16) || (j == J_32);
  endfunction

endpackage

// File: rtl/rice_opt_decode.sv
// Combinational option-ID decoder.
// Ports:
//   id_i        coded option ID
//   j_i         block size (legality only)
//   n_i         bits per sample
//   k_c_o       split bits for the block
//   zero_c_o    option ID marks an all-zero block
//   illegal_c_o descriptor is not a legal block (bad j, n, or k >= n for split IDs)
module rice_opt_decode
  import rice_pkg::*;
(
  input  logic [ID_W-1:0]   id_i,
  input  logic [CNT_W-1:0]  j_i,
  input  logic [NCFG_W-1:0] n_i,
  output logic [CNT_W-1:0]  k_c_o,
  output logic              zero_c_o,
  output logic              illegal_c_o
);

  logic split_c;

  always_comb begin
    k_c_o       = opt_to_k(id_i, n_i);
    zero_c_o    = (id_i == ID_ZERO);
    split_c     = (id_i != ID_ZERO) && (id_i != ID_FS) && (id_i != ID_NOCOMP);
    illegal_c_o = !j_is_legal(j_i)
                || (n_i == '0)
                || (32'(n_i) > SYM_W)
                || (split_c && (k_c_o >= CNT_W'(n_i)));
  end

endmodule

// File: rtl/rice_block_sequencer.sv
// Block sequencer for the Rice split-sample reconstruction datapath.
// Accepts one descriptor per block, then drives one ldor cycle, j run cycles,
// one valid capture cycle, and holds done_valid until the downstream accepts.
// Ports:
//   clk, reset            clock and asynchronous active-low reset
//   blk_valid/blk_ready   descriptor handshake (option_id, j_cfg, n_cfg)
//   ldor, valid           datapath load and capture strobes
//   k, j, n, zero_blk     per-block datapath controls, held from accept
//   busy                  sequencer is not idle
//   done_valid/done_ready block-result handshake
//   blk_count             completed blocks, wraps
//   err                   sticky illegal-descriptor flag (RICE_SEQ_ERR_CHK_EN only)
// Optional feature macro: RICE_SEQ_ERR_CHK_EN
module rice_block_sequencer
  import rice_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 blk_valid,
  output logic                 blk_ready,
  input  logic [ID_W-1:0]      option_id,
  input  logic [5:0]           j_cfg,
  input  logic [3:0]           n_cfg,
  output logic                 ldor,
  output logic                 valid,
  output logic [5:0]           k,
  output logic [5:0]           j,
  output logic [5:0]           n,
  output logic                 zero_blk,
  output logic                 busy,
  output logic                 done_valid,
  input  logic                 done_ready,
  output logic [15:0]          blk_count
`ifdef RICE_SEQ_ERR_CHK_EN
  ,
  output logic                 err
`endif
);

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       k_q, k_d, j_q, j_d, n_q, n_d;
  logic                   zero_q, zero_d;
  logic                   ldor_q, ldor_d, valid_q, valid_d;
  logic                   busy_q, busy_d, ready_q, ready_d, done_q, done_d;
  logic [BLK_CNT_W-1:0]   count_q, count_d;
  logic                   accept_c;

  logic [CNT_W-1:0]       dec_k_c;
  logic                   dec_zero_c, dec_illegal_c, zero_acc_c;

  rice_opt_decode u_decode (
    .id_i        (option_id),
    .j_i         (j_cfg),
    .n_i         (n_cfg),
    .k_c_o       (dec_k_c),
    .zero_c_o    (dec_zero_c),
    .illegal_c_o (dec_illegal_c)
  );

  // An illegal descriptor is turned into an all-zero block when checking is on.
`ifdef RICE_SEQ_ERR_CHK_EN
  assign zero_acc_c = dec_zero_c | dec_illegal_c;
`else
  logic unused_illegal;
  assign unused_illegal = dec_illegal_c;
  assign zero_acc_c     = dec_zero_c;
`endif

  assign accept_c = (state_q == IDLE) && ready_q && blk_valid;

  // Next state, held controls and registered strobes (decoded from next state).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    j_d     = j_q;
    n_d     = n_q;
    zero_d  = zero_q;
    count_d = count_q;

    unique case (state_q)
      IDLE: begin
        if (accept_c) begin
          k_d     = dec_k_c;
          j_d     = j_cfg;
          n_d     = CNT_W'(n_cfg);
          zero_d  = zero_acc_c;
          state_d = zero_acc_c ? DONE : LOAD;
        end
      end
      LOAD: begin
        cnt_d   = j_q;
        state_d = RUN;
      end
      RUN: begin
        cnt_d = cnt_q - CNT_W'(1);
        // <= keeps a j=0 descriptor from wrapping the counter into 64 cycles
        if (cnt_q <= CNT_W'(1)) state_d = CAP;
      end
      CAP: state_d = DONE;
      DONE: begin
        if (done_ready) begin
          count_d = count_q + BLK_CNT_W'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    ldor_d  = (state_d == LOAD);
    valid_d = (state_d == CAP);
    done_d  = (state_d == DONE);
    busy_d  = (state_d != IDLE);
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      k_q     <= '0;
      j_q     <= '0;
      n_q     <= '0;
      zero_q  <= 1'b0;
      ldor_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      j_q     <= j_d;
      n_q     <= n_d;
      zero_q  <= zero_d;
      ldor_q  <= ldor_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      count_q <= count_d;
    end
  end

`ifdef RICE_SEQ_ERR_CHK_EN
  logic err_q;

  // Sticky until reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                         err_q <= 1'b0;
    else if (accept_c && dec_illegal_c) err_q <= 1'b1;
  end

  assign err = err_q;
`endif

  assign blk_ready  = ready_q;
  assign ldor       = ldor_q;
  assign valid      = valid_q;
  assign k          = k_q;
  assign j          = j_q;
  assign n          = n_q;
  assign zero_blk   = zero_q;
  assign busy       = busy_q;
  assign done_valid = done_q;
  assign blk_count  = count_q;

endmodule

// File: tb/tb_rice_block_sequencer.sv
// Self-checking bench for rice_block_sequencer: directed and random blocks
// compared against a timing/decode model written from the block rules.
module tb_rice_block_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        blk_valid, blk_ready;
  logic [3:0]  option_id;
  logic [5:0]  j_cfg;
  logic [3:0]  n_cfg;
  logic        ldor, valid;
  logic [5:0]  k, j, n;
  logic        zero_blk, busy, done_valid, done_ready;
  logic [15:0] blk_count;
`ifdef RICE_SEQ_ERR_CHK_EN
  logic        err;
  bit          exp_err = 1'b0;
`endif

  int checks    = 0;
  int errors    = 0;
  int exp_count = 0;

  always #5 clk = ~clk;

  rice_block_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .blk_valid  (blk_valid),
    .blk_ready  (blk_ready),
    .option_id  (option_id),
    .j_cfg      (j_cfg),
    .n_cfg      (n_cfg),
    .ldor       (ldor),
    .valid      (valid),
    .k          (k),
    .j          (j),
    .n          (n),
    .zero_blk   (zero_blk),
    .busy       (busy),
    .done_valid (done_valid),
    .done_ready (done_ready),
    .blk_count  (blk_count)
`ifdef RICE_SEQ_ERR_CHK_EN
    ,
    .err        (err)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_k(input int id, input int nn);
    if (id == 0 || id == 1) return 0;
    if (id == 15)           return nn;
    return id - 1;
  endfunction

  function automatic bit ref_illegal(input int id, input int jj, input int nn);
`ifdef RICE_SEQ_ERR_CHK_EN
    if (!(jj == 8 || jj == 16 || jj == 32)) return 1'b1;
    if (nn == 0 || nn > 10)                 return 1'b1;
    if (id >= 2 && id <= 14 && (id - 1) >= nn) return 1'b1;
`endif
    return 1'b0;
  endfunction

  // One descriptor through the sequencer; done_ready withheld for 'hold' DONE cycles.
  task automatic run_block(input int id, input int jj, input int nn, input int hold);
    int k_e, lat, ldor_n, ldor_t, val_n, val_t, done_t;
    bit ill, z_e, unstable, hold_bad, busy_bad;
    k_e = ref_k(id, nn);
    ill = ref_illegal(id, jj, nn);
    z_e = (id == 0) || ill;
    lat = z_e ? 1 : jj + 3;
    ldor_n = 0; ldor_t = -1; val_n = 0; val_t = -1; done_t = -1;
    unstable = 0; hold_bad = 0; busy_bad = 0;

    for (int w = 0; w < 50 && blk_ready !== 1'b1; w++) @(negedge clk);
    chk("ready_before_accept", blk_ready, 1);
    blk_valid  = 1'b1;
    option_id  = 4'(id);
    j_cfg      = 6'(jj);
    n_cfg      = 4'(nn);
    done_ready = (hold == 0);

    for (int t = 1; t <= lat + hold; t++) begin
      @(negedge clk);
      blk_valid = 1'b0;
      option_id = 4'($urandom);
      j_cfg     = 6'($urandom);
      n_cfg     = 4'($urandom);
      if (ldor === 1'b1) begin ldor_n++; ldor_t = t; end
      if (valid === 1'b1) begin val_n++; val_t = t; end
      if (done_valid === 1'b1 && done_t < 0) done_t = t;
      if (busy !== 1'b1) busy_bad = 1;
      if (j !== 6'(jj) || n !== 6'(nn) || zero_blk !== z_e || (!ill && k !== 6'(k_e)))
        unstable = 1;
      if (t >= lat && (done_valid !== 1'b1 || blk_ready !== 1'b0)) hold_bad = 1;
      if (t == lat + hold) done_ready = 1'b1;
    end
    @(negedge clk);
    done_ready = 1'b0;
    exp_count  = (exp_count + 1) % 65536;
`ifdef RICE_SEQ_ERR_CHK_EN
    exp_err = exp_err | ill;
    chk("err_flag", err, exp_err);
`endif
    chk("ldor_pulses", ldor_n, z_e ? 0 : 1);
    chk("ldor_cycle", ldor_t, z_e ? -1 : 1);
    chk("valid_pulses", val_n, z_e ? 0 : 1);
    chk("valid_cycle", val_t, z_e ? -1 : jj + 2);
    chk("done_latency", done_t, lat);
    chk("controls_held", unstable, 0);
    chk("done_hold_backpressure", hold_bad, 0);
    chk("busy_in_block", busy_bad, 0);
    chk("done_cleared", done_valid, 0);
    chk("blk_count", blk_count, exp_count);
    chk("ready_after_done", blk_ready, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int lt[$];
    bit saw_valid;
    reset = 1'b0; blk_valid = 1'b0; option_id = '0; j_cfg = '0; n_cfg = '0;
    done_ready = 1'b0;
    #12;
    chk("rst_ready", blk_ready, 0);
    chk("rst_strobes", {ldor, valid, zero_blk, busy, done_valid}, 0);
    chk("rst_controls", {k, j, n}, 0);
    chk("rst_count", blk_count, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("idle_ready", blk_ready, 1);
    chk("idle_busy", busy, 0);

    // Directed blocks.
    run_block(3, 16, 8, 0);
    run_block(0, 8, 4, 0);
    run_block(15, 32, 10, 5);
    run_block(1, 8, 5, 2);

    // done_ready outside DONE is ignored.
    done_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_done_ready_count", blk_count, exp_count);
    chk("idle_done_ready_dv", done_valid, 0);
    done_ready = 1'b0;

    // Reset in the fourth RUN cycle of a j=32 block.
    blk_valid = 1'b1; option_id = 4'd5; j_cfg = 6'd32; n_cfg = 4'd8; done_ready = 1'b1;
    for (int t = 1; t <= 5; t++) begin
      @(negedge clk);
      blk_valid = 1'b0;
    end
    #2 reset = 1'b0;
    #1;
    chk("midrst_strobes", {blk_ready, ldor, valid, zero_blk, busy, done_valid}, 0);
    chk("midrst_controls", {k, j, n}, 0);
    chk("midrst_count", blk_count, 0);
    exp_count = 0;
`ifdef RICE_SEQ_ERR_CHK_EN
    exp_err = 1'b0;
`endif
    saw_valid = 0;
    repeat (3) begin
      @(negedge clk);
      if (valid !== 1'b0) saw_valid = 1;
    end
    reset = 1'b1;
    done_ready = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (valid !== 1'b0) saw_valid = 1;
    end
    chk("midrst_no_valid", saw_valid, 0);
    run_block(7, 8, 9, 1);

    // Back-to-back blocks with blk_valid and done_ready held high.
    blk_valid = 1'b1; option_id = 4'd3; j_cfg = 6'd8; n_cfg = 4'd8; done_ready = 1'b1;
    for (int t = 1; t <= 50; t++) begin
      @(negedge clk);
      if (ldor === 1'b1) lt.push_back(t);
    end
    blk_valid = 1'b0;
    for (int w = 0; w < 40 && busy !== 1'b0; w++) @(negedge clk);
    done_ready = 1'b0;
    chk("b2b_drained", busy, 0);
    chk("b2b_pulses", lt.size(), 5);
    if (lt.size() > 0) chk("b2b_first", lt[0], 1);
    for (int i = 1; i < lt.size(); i++) chk("b2b_interval", lt[i] - lt[i-1], 12);
    exp_count = (exp_count + 5) % 65536;
    chk("b2b_count", blk_count, exp_count);

`ifdef RICE_SEQ_ERR_CHK_EN
    run_block(3, 12, 8, 0);
    run_block(4, 16, 8, 0);
`endif

    // Randomized descriptors.
    for (int r = 0; r < 12; r++) begin
      int id, jj, nn;
      id = int'($urandom_range(0, 15));
      case ($urandom_range(0, 2))
        0:       jj = 8;
        1:       jj = 16;
        default: jj = 32;
      endcase
      nn = int'($urandom_range(1, 10));
      run_block(id, jj, nn, int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
